// File: rtl/md_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : md_scheduler_if
// Brief  : E-stage request / HI-LO result bundle of the multiply-divide unit.
// Rev    : 1.0  initial release
// ============================================================================
interface md_scheduler_if;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_md_instr;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  modport master (
    output e_valid, e_md_op, e_rs, e_rt, d_md_instr,
    input  start, busy, md_stall, md_done, hi, lo, mf_data
  );

  modport slave (
    input  e_valid, e_md_op, e_rs, e_rt, d_md_instr,
    output start, busy, md_stall, md_done, hi, lo, mf_data
  );
endinterface
`default_nettype wire

// File: rtl/md_scheduler.sv
`default_nettype none
// ============================================================================
// Module : md_scheduler
// Brief  : Fixed-latency mult/div sequencer that owns HI/LO in the E stage.
// Rev    : 1.0  initial release
// ============================================================================
module md_scheduler #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_scheduler_if.slave md
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_MBUSY = 2'd1;
  localparam logic [1:0] C_DBUSY = 2'd2;

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MFHI  = 4'd5;
  localparam logic [3:0] C_OP_MTHI  = 4'd7;
  localparam logic [3:0] C_OP_MTLO  = 4'd8;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [63:0]      pending_q, pending_d;
  logic             divz_q,    divz_d;
  logic [31:0]      hi_q,      hi_d;
  logic [31:0]      lo_q,      lo_d;
  logic             md_done_q, md_done_d;

  logic w_busy;
  logic w_accept;
  logic w_is_mul;
  logic w_is_div;
  logic w_signed;
  logic w_start;
  logic w_cnt_last;

  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // ------------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------------
  assign w_busy     = (state_q != C_IDLE);
  assign w_accept   = md.e_valid & ~w_busy;
  assign w_is_mul   = (md.e_md_op == C_OP_MULT) | (md.e_md_op == C_OP_MULTU);
  assign w_is_div   = (md.e_md_op == C_OP_DIV)  | (md.e_md_op == C_OP_DIVU);
  assign w_signed   = (md.e_md_op == C_OP_MULT) | (md.e_md_op == C_OP_DIV);
  assign w_start    = w_accept & (w_is_mul | w_is_div);
  assign w_cnt_last = (cnt_q == C_CNT_ONE);

  // ------------------------------------------------------------------------
  // Datapath: one 64x64 multiplier serves both signednesses because the
  // low 64 bits of a sign-extended product equal the signed 32x32 result.
  // ------------------------------------------------------------------------
  always_comb begin
    w_a_ext = {{32{w_signed & md.e_rs[31]}}, md.e_rs};
    w_b_ext = {{32{w_signed & md.e_rt[31]}}, md.e_rt};
    w_prod  = w_a_ext * w_b_ext;
  end

  // Divide on magnitudes, then restore signs; the zero divisor is replaced by
  // one so the divider never sees it (its result is never committed anyway).
  always_comb begin
    w_neg_a = w_signed & md.e_rs[31];
    w_neg_b = w_signed & md.e_rt[31];
    w_mag_a = w_neg_a ? (~md.e_rs + 32'd1) : md.e_rs;
    if (md.e_rt == 32'd0) begin
      w_mag_b = 32'd1;
    end else begin
      w_mag_b = w_neg_b ? (~md.e_rt + 32'd1) : md.e_rt;
    end
    w_uquo = w_mag_a / w_mag_b;
    w_urem = w_mag_a % w_mag_b;
    w_quo  = (w_neg_a ^ w_neg_b) ? (~w_uquo + 32'd1) : w_uquo;
    w_rem  = w_neg_a ? (~w_urem + 32'd1) : w_urem;
  end

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= C_IDLE;
      cnt_q     <= C_CNT_ZERO;
      pending_q <= 64'd0;
      divz_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      md_done_q <= md_done_d;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (w_start && w_is_mul) begin
          state_d = C_MBUSY;
          cnt_d   = C_MULT_CNT;
        end else if (w_start && w_is_div) begin
          state_d = C_DBUSY;
          cnt_d   = C_DIV_CNT;
        end
      end
      C_MBUSY, C_DBUSY: begin
        cnt_d = cnt_q - C_CNT_ONE;
        if (w_cnt_last) begin
          state_d = C_IDLE;
        end
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = C_CNT_ZERO;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Output / register-file logic
  // ------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    md_done_d = 1'b0;

    if (w_start) begin
      pending_d = w_is_mul ? w_prod : {w_rem, w_quo};
      divz_d    = w_is_div & (md.e_rt == 32'd0);
    end

    if (w_accept && (md.e_md_op == C_OP_MTHI)) begin
      hi_d = md.e_rs;
    end
    if (w_accept && (md.e_md_op == C_OP_MTLO)) begin
      lo_d = md.e_rs;
    end

    // Commit on the final busy edge; a zero-divisor op keeps HI/LO intact.
    if (w_busy && w_cnt_last) begin
      md_done_d = 1'b1;
      if (!divz_q) begin
        hi_d = pending_q[63:32];
        lo_d = pending_q[31:0];
      end
    end
  end

  assign md.start    = w_start;
  assign md.busy     = w_busy;
  assign md.md_stall = md.d_md_instr & (w_start | w_busy);
  assign md.md_done  = md_done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.mf_data  = (md.e_md_op == C_OP_MFHI) ? hi_q : lo_q;

endmodule
`default_nettype wire
